vector_add: RTL and testbench

- Element-wise signed vector adder with independent valid/ready handshakes on operands `a` and `b` and on `result`.
- Captures both operand vectors, then adds TILING cell pairs per clock until all VECTOR_LEN cells are done.
- Presents the packed sum vector with an overflow `error` flag.
- Used in the backpropagation datapath, e.g. bias/delta accumulation.

---
 rtl/vector_add.sv | 144 ++++++++++++++
 tb/tb_vector_add.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vector_add.sv
// Element-wise signed vector adder: captures a/b, adds TILING cells per clock, holds the sum until accepted.
// Define VECTOR_ADD_SATURATE_EN to clamp overflowing cells instead of wrapping them.

module vector_add_cell #(
  parameter int AW = 8,
  parameter int BW = 8,
  parameter int RW = 8
) (
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  output logic        [RW-1:0] sum,
  output logic                 ovf
);
  localparam int SW = ((AW > BW) ? AW : BW) + 1;
  localparam int CW = ((SW > RW) ? SW : RW) + 1;
  localparam logic signed [CW-1:0] MAXV = CW'((64'sd1 <<< (RW-1)) - 64'sd1);
  localparam logic signed [CW-1:0] MINV = ~MAXV;

  logic signed [CW-1:0] ax, bx, s;

  // Extra headroom bit keeps the sum exact so the range check is a plain compare.
  assign ax  = CW'(a);
  assign bx  = CW'(b);
  assign s   = ax + bx;
  assign ovf = (s > MAXV) || (s < MINV);

`ifdef VECTOR_ADD_SATURATE_EN
  assign sum = ovf ? (s[CW-1] ? MINV[RW-1:0] : MAXV[RW-1:0]) : s[RW-1:0];
`else
  assign sum = s[RW-1:0];
`endif
endmodule

module vector_add #(
  parameter int VECTOR_LEN        = 5,
  parameter int A_CELL_WIDTH      = 8,
  parameter int B_CELL_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 8,
  parameter int TILING            = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]        a,
  input  logic                                      a_valid,
  output logic                                      a_ready,
  input  logic [VECTOR_LEN*B_CELL_WIDTH-1:0]        b,
  input  logic                                      b_valid,
  output logic                                      b_ready,
  output logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0]   result,
  output logic                                      result_valid,
  input  logic                                      result_ready,
  output logic                                      error
);
  localparam int NCHUNK = (VECTOR_LEN + TILING - 1) / TILING;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t state, state_nxt;

  logic [VECTOR_LEN-1:0][A_CELL_WIDTH-1:0]      a_q;
  logic [VECTOR_LEN-1:0][B_CELL_WIDTH-1:0]      b_q;
  logic [VECTOR_LEN-1:0][RESULT_CELL_WIDTH-1:0] sum, res_q;
  logic [VECTOR_LEN-1:0]                        ovf, sel;
  logic [IW-1:0]                                chunk;
  logic a_got, b_got, a_acc, b_acc, both;

  assign a_ready = (state == IDLE) && !a_got;
  assign b_ready = (state == IDLE) && !b_got;
  assign a_acc   = a_valid && a_ready;
  assign b_acc   = b_valid && b_ready;
  // The second operand may arrive on the same edge we leave IDLE.
  assign both    = (a_got || a_acc) && (b_got || b_acc);
  assign result  = res_q;

  for (genvar i = 0; i < VECTOR_LEN; i++) begin : g_cell
    vector_add_cell #(
      .AW(A_CELL_WIDTH), .BW(B_CELL_WIDTH), .RW(RESULT_CELL_WIDTH)
    ) u_cell (
      .a(a_q[i]), .b(b_q[i]), .sum(sum[i]), .ovf(ovf[i])
    );
    assign sel[i] = (chunk == IW'(i / TILING));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (both) state_nxt = COMPUTE;
      COMPUTE: if (chunk == LAST) state_nxt = DONE;
      DONE:    if (result_valid && result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      a_got        <= 1'b0;
      b_got        <= 1'b0;
      res_q        <= '0;
      error        <= 1'b0;
      result_valid <= 1'b0;
      chunk        <= '0;
    end else begin
      if (a_acc) begin
        a_q   <= a;
        a_got <= 1'b1;
      end
      if (b_acc) begin
        b_q   <= b;
        b_got <= 1'b1;
      end
      case (state)
        IDLE: if (both) begin
          chunk <= '0;
          error <= 1'b0;
        end
        COMPUTE: begin
          chunk <= chunk + 1'b1;
          for (int i = 0; i < VECTOR_LEN; i++)
            if (sel[i]) res_q[i] <= sum[i];
          error <= error | (|(ovf & sel));
        end
        DONE: begin
          // Valid is registered, so it rises one edge after entering DONE.
          if (result_valid && result_ready) begin
            result_valid <= 1'b0;
            a_got        <= 1'b0;
            b_got        <= 1'b0;
          end else begin
            result_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_add.sv
// Directed bench for vector_add: transaction model checked every cycle on the TILING=2 instance,
// plus latency/sum checks on TILING=1 and TILING=VECTOR_LEN instances sharing the same stimulus.

module tb_vector_add;
  localparam int VL = 5;
  localparam int AW = 8;
  localparam int BW = 8;
  localparam int RW = 8;
  localparam int LAT2 = (VL + 1) / 2 + 1;

  localparam logic [VL*AW-1:0] A1 = 40'hCE281E14F6; // -50,40,30,20,-10
  localparam logic [VL*BW-1:0] B1 = 40'h0102FD0405; // 1,2,-3,4,5
  localparam logic [VL*AW-1:0] A2 = 40'h7F801E14F6; // 127,-128,30,20,-10
  localparam logic [VL*BW-1:0] B2 = 40'h7F80FD0405; // 127,-128,-3,4,5
  localparam logic [VL*RW-1:0] EXP_BASIC = 40'hCF2A1B18FB;
  localparam logic [VL*RW-1:0] EXP_MIX   = 40'h4DA81B18FB; // A1 + B2
`ifdef VECTOR_ADD_SATURATE_EN
  localparam logic [VL*RW-1:0] EXP_OVF   = 40'h7F801B18FB;
`else
  localparam logic [VL*RW-1:0] EXP_OVF   = 40'hFE001B18FB;
`endif

  logic clk = 1'b0;
  logic rst, a_valid, b_valid, result_ready;
  logic [VL*AW-1:0] a;
  logic [VL*BW-1:0] b;
  logic [VL*RW-1:0] r1, r2, r5;
  logic rv1, rv2, rv5, ar1, ar2, ar5, br1, br2, br5, e1, e2, e5;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  vector_add #(.VECTOR_LEN(VL), .A_CELL_WIDTH(AW), .B_CELL_WIDTH(BW),
    .RESULT_CELL_WIDTH(RW), .TILING(2)) u_t2 (
    .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .a_ready(ar2),
    .b(b), .b_valid(b_valid), .b_ready(br2), .result(r2),
    .result_valid(rv2), .result_ready(result_ready), .error(e2));

  vector_add #(.VECTOR_LEN(VL), .A_CELL_WIDTH(AW), .B_CELL_WIDTH(BW),
    .RESULT_CELL_WIDTH(RW), .TILING(1)) u_t1 (
    .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .a_ready(ar1),
    .b(b), .b_valid(b_valid), .b_ready(br1), .result(r1),
    .result_valid(rv1), .result_ready(result_ready), .error(e1));

  vector_add #(.VECTOR_LEN(VL), .A_CELL_WIDTH(AW), .B_CELL_WIDTH(BW),
    .RESULT_CELL_WIDTH(RW), .TILING(VL)) u_t5 (
    .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .a_ready(ar5),
    .b(b), .b_valid(b_valid), .b_ready(br5), .result(r5),
    .result_valid(rv5), .result_ready(result_ready), .error(e5));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Plain integer arithmetic over each cell pair.
  function automatic void model_sum(input logic [VL*AW-1:0] av, input logic [VL*BW-1:0] bv,
                                    output logic [VL*RW-1:0] r, output logic e);
    int s, mx, mn;
    mx = (1 << (RW - 1)) - 1;
    mn = -(1 << (RW - 1));
    e = 1'b0;
    r = '0;
    for (int i = 0; i < VL; i++) begin
      s = int'($signed(av[i*AW +: AW])) + int'($signed(bv[i*BW +: BW]));
      if (s > mx || s < mn) begin
        e = 1'b1;
`ifdef VECTOR_ADD_SATURATE_EN
        s = (s > mx) ? mx : mn;
`endif
      end
      r[i*RW +: RW] = RW'(s);
    end
  endfunction

  // Transaction model: pending operands, a countdown while busy, then a held result.
  logic m_ah = 0, m_bh = 0, m_busy = 0, m_rv = 0, m_err = 0;
  int m_cnt = 0;
  logic [VL*AW-1:0] m_a = '0;
  logic [VL*BW-1:0] m_b = '0;
  logic [VL*RW-1:0] m_res = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_ah = 0; m_bh = 0; m_busy = 0; m_rv = 0;
    end else if (m_rv) begin
      if (result_ready) begin
        m_rv = 0; m_ah = 0; m_bh = 0;
      end
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 0;
        m_rv = 1;
      end
    end else begin
      if (a_valid && !m_ah) begin m_ah = 1; m_a = a; end
      if (b_valid && !m_bh) begin m_bh = 1; m_b = b; end
      if (m_ah && m_bh) begin
        m_busy = 1;
        m_cnt = LAT2;
        model_sum(m_a, m_b, m_res, m_err);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_ready", ar2, !m_busy && !m_rv && !m_ah);
      chk("b_ready", br2, !m_busy && !m_rv && !m_bh);
      chk("result_valid", rv2, m_rv);
      if (m_rv) begin
        chk("result", r2, m_res);
        chk("error", e2, m_err);
      end
    end
  end

  task automatic wait_rv(input string nm);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (rv2) got = 1'b1;
    end
    chk(nm, got, 1'b1);
  endtask

  initial begin
    int lat1, lat2, lat5;
    logic [VL*RW-1:0] s1, s2, s5;
    logic se1, se2, se5;
    rst = 1; a = '0; b = '0; a_valid = 0; b_valid = 0; result_ready = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    chk("rst_rv", rv2, 0); chk("rst_err", e2, 0); chk("rst_ardy", ar2, 1);
    chk("rst_brdy", br2, 1); chk("rst_result", r2, 0);
    rst = 0;

    // a first, b five cycles later, consumer stalled
    a = A1; a_valid = 1;
    repeat (3) @(negedge clk);
    a_valid = 0; a = 40'h1122334455;
    repeat (2) @(negedge clk);
    chk("a_capt_ardy", ar2, 0); chk("a_capt_brdy", br2, 1);
    b = B1; b_valid = 1;
    repeat (3) @(negedge clk);
    b_valid = 0; b = 40'h5544332211;
    wait_rv("basic_rv_timeout");
    chk("basic_result", r2, EXP_BASIC); chk("basic_err", e2, 0);
    repeat (5) @(negedge clk);
    chk("hold_rv", rv2, 1); chk("hold_result", r2, EXP_BASIC);
    result_ready = 1;
    @(negedge clk);
    result_ready = 0;
    chk("rel_rv", rv2, 0); chk("rel_ardy", ar2, 1); chk("rel_brdy", br2, 1);
    chk("rel_result_kept", r2, EXP_BASIC);

    // overflow pair, same cycle, consumer always ready; latency per tiling
    result_ready = 1; a = A2; b = B2; a_valid = 1; b_valid = 1;
    lat1 = 0; lat2 = 0; lat5 = 0;
    s1 = '0; s2 = '0; s5 = '0; se1 = 0; se2 = 0; se5 = 0;
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (rv1 && lat1 == 0) begin lat1 = n; s1 = r1; se1 = e1; end
      if (rv2 && lat2 == 0) begin lat2 = n; s2 = r2; se2 = e2; end
      if (rv5 && lat5 == 0) begin lat5 = n; s5 = r5; se5 = e5; end
    end
    chk("lat_t1", lat1, VL + 1); chk("lat_t2", lat2, 4); chk("lat_t5", lat5, 2);
    chk("ovf_t1", s1, EXP_OVF); chk("ovf_t2", s2, EXP_OVF); chk("ovf_t5", s5, EXP_OVF);
    chk("ovf_err_t1", se1, 1); chk("ovf_err_t2", se2, 1); chk("ovf_err_t5", se5, 1);
    chk("ovf_t2_done_rv", rv2, 0);

    // reset in the middle of a computation
    @(negedge clk);
    a = A1; b = B1; a_valid = 1; b_valid = 1;
    @(negedge clk);
    a_valid = 0; b_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rstc_ardy", ar2, 1); chk("rstc_brdy", br2, 1);
    chk("rstc_ardy_t1", ar1, 1); chk("rstc_ardy_t5", ar5, 1);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("rstc_rv", {rv1, rv2, rv5}, 3'b000);
    end
    a = A1; b = B2; a_valid = 1; b_valid = 1;
    @(negedge clk);
    a_valid = 0; b_valid = 0;
    wait_rv("mix_rv_timeout");
    chk("mix_result", r2, EXP_MIX); chk("mix_err", e2, 0);
    repeat (8) @(negedge clk);
    chk("mix_result_t1", r1, EXP_MIX); chk("mix_result_t5", r5, EXP_MIX);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
